// File: rtl/sha256_block_sequencer.sv
// Control sequencer for a SHA-256 core: loads 16-word blocks, steps the compression
// rounds, accumulates the hash per block and streams the digest out.
module sha256_block_sequencer #(
    parameter int ROUNDS       = 64,
    parameter int DIGEST_WORDS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        w_valid,
    output logic        w_ready,
    input  logic        last,
    input  logic        digest_ready,
    output logic        digest_valid,
    output logic [3:0]  mem_in_addr,
    output logic        en_mem_in,
    output logic [5:0]  k_num,
    output logic        en_round,
    output logic        init_hash,
    output logic        add_hash,
    output logic [3:0]  mem_out_addr,
    output logic        en_mem_out,
    output logic        busy,
    output logic [15:0] blk_cnt,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_ROUND,
        S_ADD,
        S_OUT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  mem_in_addr_q, mem_in_addr_d;
    logic [5:0]  k_num_q, k_num_d;
    logic [3:0]  mem_out_addr_q, mem_out_addr_d;
    logic [15:0] blk_cnt_q, blk_cnt_d;
    logic        last_flag_q, last_flag_d;
    logic        done_q, done_d;

    logic        round_end;
    logic        out_end;

    assign round_end = (k_num_q == 6'(ROUNDS - 1));
    assign out_end   = (mem_out_addr_q == 4'(DIGEST_WORDS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            mem_in_addr_q  <= '0;
            k_num_q        <= '0;
            mem_out_addr_q <= '0;
            blk_cnt_q      <= '0;
            last_flag_q    <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_in_addr_q  <= mem_in_addr_d;
            k_num_q        <= k_num_d;
            mem_out_addr_q <= mem_out_addr_d;
            blk_cnt_q      <= blk_cnt_d;
            last_flag_q    <= last_flag_d;
            done_q         <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_INIT;
                S_INIT:  state_d = S_LOAD;
                S_LOAD:  if (w_valid && mem_in_addr_q == 4'd15) state_d = S_ROUND;
                S_ROUND: if (round_end) state_d = S_ADD;
                S_ADD:   state_d = last_flag_q ? S_OUT : S_LOAD;
                S_OUT:   if (digest_ready && out_end) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Counters and flags advance alongside the state; abort wipes them all.
    always_comb begin
        mem_in_addr_d  = mem_in_addr_q;
        k_num_d        = k_num_q;
        mem_out_addr_d = mem_out_addr_q;
        blk_cnt_d      = blk_cnt_q;
        last_flag_d    = last_flag_q;
        done_d         = 1'b0;
        if (abort) begin
            mem_in_addr_d  = '0;
            k_num_d        = '0;
            mem_out_addr_d = '0;
            blk_cnt_d      = '0;
            last_flag_d    = 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    blk_cnt_d     = '0;
                    mem_in_addr_d = '0;
                    last_flag_d   = 1'b0;
                end
                S_LOAD: begin
                    if (w_valid) begin
                        mem_in_addr_d = mem_in_addr_q + 4'd1;
                        if (mem_in_addr_q == 4'd15) begin
                            last_flag_d = last;
                            k_num_d     = '0;
                        end
                    end
                end
                S_ROUND: k_num_d = round_end ? 6'd0 : k_num_q + 6'd1;
                S_ADD: begin
                    blk_cnt_d = blk_cnt_q + 16'd1;
                    if (last_flag_q) mem_out_addr_d = '0;
                end
                S_OUT: begin
                    if (digest_ready) begin
                        if (out_end) begin
                            mem_out_addr_d = '0;
                            done_d         = 1'b1;
                        end else begin
                            mem_out_addr_d = mem_out_addr_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_ready      = (state_q == S_LOAD);
        en_mem_in    = w_valid && (state_q == S_LOAD);
        en_round     = (state_q == S_ROUND);
        init_hash    = (state_q == S_INIT);
        add_hash     = (state_q == S_ADD);
        digest_valid = (state_q == S_OUT);
        en_mem_out   = (state_q == S_OUT);
        busy         = (state_q != S_IDLE);
        mem_in_addr  = mem_in_addr_q;
        k_num        = k_num_q;
        mem_out_addr = mem_out_addr_q;
        blk_cnt      = blk_cnt_q;
        done         = done_q;
    end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Self-checking bench for sha256_block_sequencer: drives whole messages block by block
// and checks every phase against the expected load/round/add/output sequence.
module tb_sha256_block_sequencer;

    localparam int ROUNDS = 64;
    localparam int DW     = 8;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        w_valid;
    logic        w_ready;
    logic        last;
    logic        digest_ready;
    logic        digest_valid;
    logic [3:0]  mem_in_addr;
    logic        en_mem_in;
    logic [5:0]  k_num;
    logic        en_round;
    logic        init_hash;
    logic        add_hash;
    logic [3:0]  mem_out_addr;
    logic        en_mem_out;
    logic        busy;
    logic [15:0] blk_cnt;
    logic        done;

    int errorCount = 0;
    int checkCount = 0;
    int expBlk     = 0;

    sha256_block_sequencer #(.ROUNDS(ROUNDS), .DIGEST_WORDS(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .w_valid(w_valid), .w_ready(w_ready), .last(last),
        .digest_ready(digest_ready), .digest_valid(digest_valid),
        .mem_in_addr(mem_in_addr), .en_mem_in(en_mem_in), .k_num(k_num),
        .en_round(en_round), .init_hash(init_hash), .add_hash(add_hash),
        .mem_out_addr(mem_out_addr), .en_mem_out(en_mem_out), .busy(busy),
        .blk_cnt(blk_cnt), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // The four strobes are mutually exclusive on every cycle.
    always @(negedge clk) begin
        if (!reset)
            checkOutput("strobes_exclusive",
                        32'($countones({init_hash, en_round, add_hash, done}) <= 1), 32'd1);
    end

    // mode 0: no stalls, mode 1: random stalls and noise, mode 2: fixed backpressure.
    task automatic applyStimulus(input int nBlocks, input int mode);
        int gaps;
        start = 1'b1;
        #1;
        checkOutput("idle_busy", busy, 0);
        tick;
        start = 1'b0;
        #1;
        checkOutput("init_hash", init_hash, 1);
        checkOutput("init_busy", busy, 1);
        checkOutput("init_w_ready", w_ready, 0);
        tick;
        expBlk = 0;
        for (int b = 0; b < nBlocks; b++) begin
            for (int w = 0; w < 16; w++) begin
                gaps = (mode == 1) ? int'($urandom_range(0, 2)) : ((mode == 2) ? 1 : 0);
                for (int g = 0; g < gaps; g++) begin
                    w_valid = 1'b0;
                    last    = (mode == 1) ? 1'($urandom) : 1'b0;
                    #1;
                    checkOutput("stall_w_ready", w_ready, 1);
                    checkOutput("stall_en_mem_in", en_mem_in, 0);
                    checkOutput("stall_addr", mem_in_addr, w);
                    tick;
                end
                w_valid = 1'b1;
                if (w == 15) last = (b == nBlocks - 1);
                else         last = (mode == 1) ? 1'($urandom) : 1'b0;
                #1;
                checkOutput("load_w_ready", w_ready, 1);
                checkOutput("load_en_mem_in", en_mem_in, 1);
                checkOutput("load_addr", mem_in_addr, w);
                checkOutput("load_blk_cnt", blk_cnt, expBlk);
                checkOutput("load_no_init", init_hash, 0);
                tick;
            end
            w_valid = 1'b0;
            last    = 1'b0;
            for (int r = 0; r < ROUNDS; r++) begin
                if (mode == 1) begin
                    w_valid = 1'($urandom);
                    start   = 1'($urandom);
                end
                #1;
                checkOutput("round_en", en_round, 1);
                checkOutput("round_k", k_num, r);
                checkOutput("round_w_ready", w_ready, 0);
                checkOutput("round_en_mem_in", en_mem_in, 0);
                tick;
            end
            w_valid = 1'b0;
            start   = 1'b0;
            #1;
            checkOutput("add_hash", add_hash, 1);
            checkOutput("add_k", k_num, 0);
            checkOutput("add_blk_cnt", blk_cnt, expBlk);
            tick;
            expBlk++;
            checkOutput("post_add_blk_cnt", blk_cnt, expBlk);
        end
        for (int d = 0; d < DW; d++) begin
            gaps = (mode == 1) ? int'($urandom_range(0, 2)) : ((mode == 2 && d == 0) ? 5 : 0);
            for (int g = 0; g < gaps; g++) begin
                digest_ready = 1'b0;
                #1;
                checkOutput("out_stall_valid", digest_valid, 1);
                checkOutput("out_stall_addr", mem_out_addr, d);
                tick;
            end
            digest_ready = 1'b1;
            #1;
            checkOutput("out_valid", digest_valid, 1);
            checkOutput("out_en", en_mem_out, 1);
            checkOutput("out_addr", mem_out_addr, d);
            checkOutput("out_blk_cnt", blk_cnt, expBlk);
            checkOutput("out_no_done", done, 0);
            tick;
        end
        digest_ready = 1'b0;
        #1;
        checkOutput("done_pulse", done, 1);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_valid", digest_valid, 0);
        tick;
        #1;
        checkOutput("done_cleared", done, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        w_valid = 1'b0; last = 1'b0; digest_ready = 1'b0;
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_k", k_num, 0);
        checkOutput("rst_in_addr", mem_in_addr, 0);
        checkOutput("rst_out_addr", mem_out_addr, 0);
        checkOutput("rst_blk_cnt", blk_cnt, 0);
        checkOutput("rst_strobes", {init_hash, en_round, add_hash, done, w_ready, digest_valid}, 0);
        @(negedge clk);
        reset = 1'b0;
        tick;

        applyStimulus(1, 0);
        applyStimulus(2, 0);
        applyStimulus(1, 2);
        for (int m = 0; m < 4; m++) applyStimulus(int'($urandom_range(1, 3)), 1);

        // Abort in the middle of the rounds.
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        w_valid = 1'b1;
        for (int w = 0; w < 16; w++) tick;
        w_valid = 1'b0;
        for (int r = 0; r <= 30; r++) begin
            if (r == 30) abort = 1'b1;
            #1;
            checkOutput("abort_k_before", k_num, r);
            tick;
        end
        abort = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_k", k_num, 0);
        checkOutput("abort_blk_cnt", blk_cnt, 0);
        checkOutput("abort_en_round", en_round, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("abort_no_add", add_hash, 0);
            checkOutput("abort_no_done", done, 0);
            checkOutput("abort_idle", busy, 0);
            tick;
        end

        // Asynchronous reset between edges in the middle of a block load.
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        w_valid = 1'b1;
        for (int w = 0; w < 5; w++) tick;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("areset_w_ready", w_ready, 0);
        checkOutput("areset_en_mem_in", en_mem_in, 0);
        checkOutput("areset_addr", mem_in_addr, 0);
        checkOutput("areset_busy", busy, 0);
        #3;
        reset = 1'b0;
        w_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checkOutput("post_reset_idle", busy, 0);
        end

        // start together with abort in IDLE stays idle.
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        #1;
        checkOutput("start_abort_busy", busy, 0);
        checkOutput("start_abort_init", init_hash, 0);

        applyStimulus(1, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sha256_block_sequencer.md
SHA256_BLOCK_SEQUENCER -- requirements
Module: sha256_block_sequencer

Interface
REQ-001 SHALL have parameter ROUNDS, default 64, compression rounds per block (k_num sweeps 0..ROUNDS-1).
REQ-002 SHALL have parameter DIGEST_WORDS, default 8, hash words streamed out per message.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  input  1  begin new message; honoured only in IDLE.
REQ-006 abort  input  1  synchronous abort to IDLE from any state.
REQ-007 w_valid  input  1  message word on datapath input is valid.
REQ-008 w_ready  output  1  sequencer accepts a word this cycle.
REQ-009 last  input  1  current block is final; sampled only with 16th accepted word.
REQ-010 digest_ready  input  1  consumer takes current digest word.
REQ-011 digest_valid  output  1  digest word at mem_out_addr is presented.
REQ-012 mem_in_addr  output  4  write address of word buffer, 0..15.
REQ-013 en_mem_in  output  1  word buffer write enable.
REQ-014 k_num  output  6  round index to datapath.
REQ-015 en_round  output  1  datapath executes round k_num this cycle.
REQ-016 init_hash  output  1  datapath loads H0..H7 initial values.
REQ-017 add_hash  output  1  datapath adds working vars into H registers.
REQ-018 mem_out_addr  output  4  digest word index, 0..DIGEST_WORDS-1.
REQ-019 en_mem_out  output  1  digest read enable.
REQ-020 busy  output  1  high in every state except IDLE.
REQ-021 blk_cnt  output  16  blocks compressed in current message.
REQ-022 done  output  1  one-cycle pulse after last digest word accepted.

Function
REQ-023 States: IDLE, INIT, LOAD, ROUND, ADD, OUT; state register SHALL be the only sequencing source.
REQ-024 IDLE: start=1 and abort=0 -> INIT; otherwise stay; start outside IDLE SHALL be ignored.
REQ-025 INIT: init_hash=1 for exactly one cycle; blk_cnt<=0; mem_in_addr<=0; -> LOAD.
REQ-026 LOAD: w_ready=1; en_mem_in = w_valid & w_ready (combinational); each accept increments mem_in_addr.
REQ-027 LOAD: accept at mem_in_addr=15 SHALL latch last into last_flag, wrap mem_in_addr to 0, set k_num<=0, -> ROUND.
REQ-028 LOAD: w_valid=0 SHALL stall with no address change, unbounded.
REQ-029 ROUND: en_round=1 every cycle; k_num increments per cycle; at k_num=ROUNDS-1 -> ADD, k_num<=0.
REQ-030 ROUND: w_ready=0 and w_valid ignored.
REQ-031 ADD: add_hash=1 for one cycle; blk_cnt increments, wrapping 0xFFFF->0x0000; last_flag=1 -> OUT with mem_out_addr<=0, else -> LOAD (no init_hash).
REQ-032 OUT: digest_valid=1, en_mem_out=1; digest_ready=1 increments mem_out_addr; accept at DIGEST_WORDS-1 -> IDLE with done=1 in that transition cycle's following cycle (IDLE first cycle).
REQ-033 OUT: digest_ready=0 SHALL hold mem_out_addr and digest_valid stable.
REQ-034 abort=1 in any state SHALL return to IDLE next edge, clear counters and last_flag, no done pulse; abort overrides start.
REQ-035 Minimum per-block latency: 16 LOAD + ROUNDS + 1 ADD cycles; start to first w_ready: 2 cycles.
REQ-036 All strobe outputs (init_hash, en_round, add_hash, done) SHALL never be high simultaneously.

Reset
REQ-037 On reset=1: state=IDLE; all outputs 0, including k_num, mem_in_addr, mem_out_addr, blk_cnt; last_flag=0.
REQ-038 Reset mid-operation SHALL abandon the message; after release, sequencer waits for a new start.

Verification
REQ-039 Single block: start, 16 words w_valid=1, last=1 on 16th -> init_hash at cycle 1, w_ready cycles 2-17, en_round cycles 18-81 with k_num 0..63, add_hash cycle 82, blk_cnt=1, 8 digest words, done pulse.
REQ-040 Two blocks, last=0 then 1 -> init_hash exactly once, add_hash twice, blk_cnt=2, single OUT phase.
REQ-041 Backpressure: w_valid toggled every other cycle, digest_ready held 0 for 5 cycles -> addresses stall, no dropped/duplicated index.
REQ-042 abort during ROUND at k_num=30 -> IDLE next cycle, busy=0, k_num=0, no add_hash, no done.
REQ-043 Async reset asserted mid-LOAD between edges -> outputs 0 immediately; start ignored in non-IDLE states; start+abort in IDLE -> stays IDLE.
